// File: rtl/spi_bus_arbiter.sv
// Shares one mode-0 SPI bus (sclk/mosi/miso, sen_n) between NREQ requesters; includes the shift engine. Optional SPI_ARB_STRICT_PRIO_EN: fixed priority, highest index wins.
// Latency: sen_n falls one cycle after handshake; rsp_valid pulses on the sen_n rise, CLK_DIV*(2*len+2) cycles later.
// Backpressure: req_ready only in IDLE and only to the granted requester; losers hold their request until granted.
module spi_bus_arbiter #(
    parameter int NREQ    = 2,
    parameter int NSLAVE  = 5,
    parameter int CLK_DIV = 2,
    parameter int GAP     = 2
) (
    input  logic                   wb_clk,
    input  logic                   wb_rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NSLAVE*NREQ-1:0] req_sel,
    input  logic [6*NREQ-1:0]      req_len,
    input  logic [32*NREQ-1:0]     req_data,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [31:0]            rsp_data,
    output logic                   busy,
    output logic                   sclk,
    output logic                   mosi,
    input  logic                   miso,
    output logic [NSLAVE-1:0]      sen_n
);

    localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t            state_q, state_n;
    logic [DW-1:0]     div_q, div_n;
    logic [GW-1:0]     gap_q, gap_n;
    logic [5:0]        bit_q, bit_n;
    logic [5:0]        len_q, len_n;
    logic [31:0]       tx_q, tx_n;
    logic [31:0]       rx_q, rx_n;
    logic [RW-1:0]     owner_q, owner_n;
    logic              sclk_q, sclk_n;
    logic              mosi_q, mosi_n;
    logic [NSLAVE-1:0] sen_n_q, sen_n_n;
    logic [NREQ-1:0]   rsp_vld_q, rsp_vld_n;
    logic [31:0]       rsp_dat_q, rsp_dat_n;
`ifndef SPI_ARB_STRICT_PRIO_EN
    logic [RW-1:0]     rr_q, rr_n;
`endif

    logic              gnt_vld;
    logic [RW-1:0]     gnt_idx;
    logic [RW-1:0]     cand;
    logic              hs;
    logic [NSLAVE-1:0] g_sel, sel_oh;
    logic [5:0]        g_len, len_eff;
    logic [31:0]       g_data, tx_aligned;

    // Grant: strict mode lets the last (highest) valid index win; round robin
    // scans downward in offset so the requester right after rr_q ends up winning.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
`ifdef SPI_ARB_STRICT_PRIO_EN
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i]) begin
                gnt_vld = 1'b1;
                gnt_idx = RW'(i);
            end
        end
`else
        for (int i = NREQ; i >= 1; i--) begin
            cand = RW'((int'(rr_q) + i) % NREQ);
            if (req_valid[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
`endif
    end

    assign hs        = (state_q == S_IDLE) && gnt_vld && !wb_rst;
    assign req_ready = hs ? (NREQ'(1) << gnt_idx) : '0;

    assign g_sel      = req_sel[gnt_idx*NSLAVE +: NSLAVE];
    assign g_len      = req_len[gnt_idx*6 +: 6];
    assign g_data     = req_data[gnt_idx*32 +: 32];
    assign sel_oh     = g_sel & (~g_sel + NSLAVE'(1));
    assign len_eff    = (g_len == 6'd0 || g_len > 6'd32) ? 6'd32 : g_len;
    // MSB of the frame parked at bit 31 so mosi always comes from tx_q[31].
    assign tx_aligned = g_data << (6'd32 - len_eff);

    always_comb begin
        state_n   = state_q;
        div_n     = div_q;
        gap_n     = gap_q;
        bit_n     = bit_q;
        len_n     = len_q;
        tx_n      = tx_q;
        rx_n      = rx_q;
        owner_n   = owner_q;
        sclk_n    = sclk_q;
        mosi_n    = mosi_q;
        sen_n_n   = sen_n_q;
        rsp_vld_n = '0;
        rsp_dat_n = rsp_dat_q;
`ifndef SPI_ARB_STRICT_PRIO_EN
        rr_n      = rr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (hs) begin
                    state_n = S_SETUP;
                    div_n   = '0;
                    bit_n   = '0;
                    len_n   = len_eff;
                    tx_n    = tx_aligned;
                    mosi_n  = tx_aligned[31];
                    rx_n    = '0;
                    sclk_n  = 1'b0;
                    sen_n_n = ~sel_oh;
                    owner_n = gnt_idx;
`ifndef SPI_ARB_STRICT_PRIO_EN
                    rr_n    = gnt_idx;
`endif
                end
            end
            S_SETUP: begin
                if (div_q == DIV_LAST) begin
                    div_n   = '0;
                    state_n = S_SHIFT;
                    sclk_n  = 1'b1;
                    rx_n    = {rx_q[30:0], miso};
                end else begin
                    div_n = div_q + DW'(1);
                end
            end
            S_SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_n = '0;
                    if (sclk_q) begin
                        sclk_n = 1'b0;
                        if (bit_q != len_q - 6'd1) begin
                            tx_n   = tx_q << 1;
                            mosi_n = tx_q[30];
                        end
                    end else if (bit_q == len_q - 6'd1) begin
                        state_n = S_HOLD;
                    end else begin
                        bit_n  = bit_q + 6'd1;
                        sclk_n = 1'b1;
                        rx_n   = {rx_q[30:0], miso};
                    end
                end else begin
                    div_n = div_q + DW'(1);
                end
            end
            S_HOLD: begin
                if (div_q == DIV_LAST) begin
                    div_n     = '0;
                    gap_n     = '0;
                    sen_n_n   = '1;
                    mosi_n    = 1'b0;
                    rsp_vld_n = NREQ'(1) << owner_q;
                    rsp_dat_n = rx_q;
                    state_n   = (GAP > 0) ? S_GAP : S_IDLE;
                end else begin
                    div_n = div_q + DW'(1);
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_n = S_IDLE;
                end else begin
                    gap_n = gap_q + GW'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            gap_q     <= '0;
            bit_q     <= '0;
            len_q     <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            owner_q   <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            sen_n_q   <= '1;
            rsp_vld_q <= '0;
            rsp_dat_q <= '0;
`ifndef SPI_ARB_STRICT_PRIO_EN
            rr_q      <= '0;
`endif
        end else begin
            state_q   <= state_n;
            div_q     <= div_n;
            gap_q     <= gap_n;
            bit_q     <= bit_n;
            len_q     <= len_n;
            tx_q      <= tx_n;
            rx_q      <= rx_n;
            owner_q   <= owner_n;
            sclk_q    <= sclk_n;
            mosi_q    <= mosi_n;
            sen_n_q   <= sen_n_n;
            rsp_vld_q <= rsp_vld_n;
            rsp_dat_q <= rsp_dat_n;
`ifndef SPI_ARB_STRICT_PRIO_EN
            rr_q      <= rr_n;
`endif
        end
    end

    assign rsp_valid = rsp_vld_q;
    assign rsp_data  = rsp_dat_q;
    assign busy      = (state_q != S_IDLE);
    assign sclk      = sclk_q;
    assign mosi      = mosi_q;
    assign sen_n     = sen_n_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Scoreboarded bench for spi_bus_arbiter: directed frames with miso looped back from mosi (or forced low).
module tb_spi_bus_arbiter;

    localparam int NREQ    = 2;
    localparam int NSLAVE  = 5;
    localparam int CLK_DIV = 2;
    localparam int GAP     = 2;

    logic                   wb_clk;
    logic                   wb_rst;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NSLAVE*NREQ-1:0] req_sel;
    logic [6*NREQ-1:0]      req_len;
    logic [32*NREQ-1:0]     req_data;
    logic [NREQ-1:0]        rsp_valid;
    logic [31:0]            rsp_data;
    logic                   busy;
    logic                   sclk;
    logic                   mosi;
    logic                   miso;
    logic [NSLAVE-1:0]      sen_n;

    logic                   v_a [NREQ];
    logic [NSLAVE-1:0]      s_a [NREQ];
    logic [5:0]             l_a [NREQ];
    logic [31:0]            d_a [NREQ];
    logic                   miso_zero;

    for (genvar g = 0; g < NREQ; g++) begin : g_pack
        assign req_valid[g]               = v_a[g];
        assign req_sel[g*NSLAVE +: NSLAVE] = s_a[g];
        assign req_len[g*6 +: 6]          = l_a[g];
        assign req_data[g*32 +: 32]       = d_a[g];
    end
    assign miso = miso_zero ? 1'b0 : mosi;

    spi_bus_arbiter #(
        .NREQ(NREQ), .NSLAVE(NSLAVE), .CLK_DIV(CLK_DIV), .GAP(GAP)
    ) dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_sel(req_sel), .req_len(req_len), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
        .sclk(sclk), .mosi(mosi), .miso(miso), .sen_n(sen_n)
    );

    initial begin
        wb_clk = 1'b0;
        forever #5 wb_clk = ~wb_clk;
    end

    typedef struct {
        int          owner;
        logic [31:0] tdata;
        logic [31:0] rdata;
        int          len;
        logic [4:0]  en;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    int          low_cnt = 0;
    int          rises = 0;
    logic [31:0] mosi_bits = '0;
    logic [4:0]  en_seen = '0;
    logic        sclk_prev = 1'b0;
    logic        pulse_chk = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_rsp(input int owner, input logic [31:0] tdata, input logic [31:0] rdata,
                              input int len, input logic [4:0] en);
        exp_t e;
        e.owner = owner; e.tdata = tdata; e.rdata = rdata; e.len = len; e.en = en;
        sb.push_back(e);
    endtask

    // Monitor: tracks bus activity per frame and scores it when rsp_valid appears.
    initial begin
        exp_t        e;
        logic [31:0] mask;
        forever begin
            @(negedge wb_clk);
            if (wb_rst) begin
                low_cnt = 0; rises = 0; mosi_bits = '0; en_seen = '0;
                sclk_prev = 1'b0; pulse_chk = 1'b0;
            end else begin
                if (pulse_chk) begin
                    check("rsp_valid_width", 32'(rsp_valid), 32'd0);
                    pulse_chk = 1'b0;
                end
                if (sen_n != 5'h1F) low_cnt++;
                en_seen = en_seen | ~sen_n;
                if (sclk && !sclk_prev) begin
                    rises++;
                    mosi_bits = {mosi_bits[30:0], mosi};
                end
                sclk_prev = sclk;
                if (rsp_valid != '0) begin
                    if (sb.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_rsp: got rsp_valid %b with nothing outstanding", rsp_valid);
                    end else begin
                        e = sb.pop_front();
                        mask = (e.len == 32) ? 32'hFFFF_FFFF : ((32'd1 << e.len) - 32'd1);
                        check("rsp_owner", 32'(rsp_valid), 32'(2'b01 << e.owner));
                        check("rsp_data", rsp_data, e.rdata);
                        check("sen_low_cycles", 32'(low_cnt),
                              (e.en == 5'd0) ? 32'd0 : 32'(CLK_DIV * (2 * e.len + 2)));
                        check("sclk_rises", 32'(rises), 32'(e.len));
                        check("mosi_bits", mosi_bits & mask, e.tdata & mask);
                        check("enable_used", 32'(en_seen), 32'(e.en));
                        check("busy_in_gap", 32'(busy), 32'd1);
                    end
                    low_cnt = 0; rises = 0; mosi_bits = '0; en_seen = '0;
                    pulse_chk = 1'b1;
                end
            end
        end
    end

    task automatic send(input int r, input logic [4:0] sel, input logic [5:0] len, input logic [31:0] data);
        bit done;
        done = 1'b0;
        @(negedge wb_clk);
        s_a[r] = sel; l_a[r] = len; d_a[r] = data; v_a[r] = 1'b1;
        for (int c = 0; c < 3000 && !done; c++) begin
            #1;
            if (req_ready[r]) begin
                @(posedge wb_clk);
                #1;
                v_a[r] = 1'b0;
                done = 1'b1;
            end else begin
                @(negedge wb_clk);
            end
        end
        vectors++;
        if (!done) begin
            miscompares++;
            v_a[r] = 1'b0;
            $display("FAIL handshake_timeout: requester %0d got no ready, required one within 3000 cycles", r);
        end
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 20000 && sb.size() != 0; c++) @(negedge wb_clk);
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
            sb.delete();
        end
        repeat (GAP + 3) @(negedge wb_clk);
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            v_a[i] = 1'b0; s_a[i] = '0; l_a[i] = '0; d_a[i] = '0;
        end
        miso_zero = 1'b0;
        wb_rst = 1'b1;

        repeat (3) @(negedge wb_clk);
        check("reset_sen_n", 32'(sen_n), 32'h1F);
        check("reset_sclk", 32'(sclk), 32'd0);
        check("reset_mosi", 32'(mosi), 32'd0);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_data", rsp_data, 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        @(posedge wb_clk);
        #1 wb_rst = 1'b0;

        // Basic 16-bit frame on LMS1.
        expect_rsp(0, 32'h8A5C, 32'h0000_8A5C, 16, 5'b00010);
        send(0, 5'b00010, 6'd16, 32'h0000_8A5C);
        wait_drain();

        // Contention: req1 queues two frames while req0 waits with one.
        expect_rsp(1, 32'h3C, 32'h3C, 8, 5'b00100);
`ifdef SPI_ARB_STRICT_PRIO_EN
        expect_rsp(1, 32'h9, 32'h9, 4, 5'b10000);
        expect_rsp(0, 32'hABC, 32'hABC, 12, 5'b01000);
`else
        expect_rsp(0, 32'hABC, 32'hABC, 12, 5'b01000);
        expect_rsp(1, 32'h9, 32'h9, 4, 5'b10000);
`endif
        fork
            begin
                send(1, 5'b00100, 6'd8, 32'h3C);
                send(1, 5'b10000, 6'd4, 32'h9);
            end
            send(0, 5'b01000, 6'd12, 32'hABC);
        join
        wait_drain();

        // len 0 means 32 bits; miso held low gives all-zero rx.
        miso_zero = 1'b1;
        expect_rsp(0, 32'hDEAD_BEEF, 32'h0, 32, 5'b00001);
        send(0, 5'b00001, 6'd0, 32'hDEAD_BEEF);
        wait_drain();
        miso_zero = 1'b0;

        // Reset in the middle of a frame drops it with no response.
        send(0, 5'b00010, 6'd16, 32'h1234);
        for (int c = 0; c < 2000 && rises < 5; c++) @(negedge wb_clk);
        check("midframe_reached_bit5", 32'(rises >= 5), 32'd1);
        @(posedge wb_clk);
        #1 wb_rst = 1'b1;
        #1;
        check("midreset_sen_n", 32'(sen_n), 32'h1F);
        check("midreset_sclk", 32'(sclk), 32'd0);
        check("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_rsp_data", rsp_data, 32'd0);
        repeat (3) @(negedge wb_clk);
        @(posedge wb_clk);
        #1 wb_rst = 1'b0;

        expect_rsp(1, 32'h2A5, 32'h2A5, 10, 5'b00001);
        send(1, 5'b00001, 6'd10, 32'h2A5);
        wait_drain();

        // Multiple sel bits: lowest wins.
        expect_rsp(0, 32'hC3, 32'hC3, 8, 5'b00100);
        send(0, 5'b10100, 6'd8, 32'hC3);
        wait_drain();

        // No enable selected: frame still clocks and completes.
        expect_rsp(0, 32'h15, 32'h15, 5, 5'b00000);
        send(0, 5'b00000, 6'd5, 32'h15);
        wait_drain();

        // Over-long length clamps to 32.
        expect_rsp(1, 32'h1357_9BDF, 32'h1357_9BDF, 32, 5'b01000);
        send(1, 5'b01000, 6'd45, 32'h1357_9BDF);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
